// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: drains a FIFO in bursts (or to empty on flush) through a
// 2-entry skid buffer onto a valid/ready output, counting delivered words.
module fifo_pop_ctrl #(
   parameter int DATA_WIDTH = 12,
   parameter int BURST_LEN  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  Reset,
   input  logic                  Enable,
   input  logic                  flush,
   input  logic                  FIFO_empty,
   input  logic                  FIFO_almost_empty,
   input  logic [DATA_WIDTH-1:0] FIFO_data_out,
   output logic                  read_enable,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  words_out
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BURST = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);

   logic [1:0]            state_r;
   logic [1:0]            state_nxt_s;
   logic [3:0]            burst_cnt_r;
   logic [3:0]            burst_cnt_nxt_s;
   logic [1:0]            occ_r;
   logic [1:0]            occ_nxt_s;
   logic                  inflight_r;
   logic [DATA_WIDTH-1:0] head_r;
   logic [DATA_WIDTH-1:0] head_nxt_s;
   logic [DATA_WIDTH-1:0] tail_r;
   logic [DATA_WIDTH-1:0] tail_nxt_s;
   logic [CNT_WIDTH-1:0]  words_out_r;
   logic                  active_s;
   logic                  pop_s;
   logic                  credit_s;
   logic                  read_s;

   // A pop in the same cycle frees a slot, which keeps 1 word/cycle
   // sustained while still never exceeding two buffered-or-pending words.
   assign active_s = (state_r == BURST) || (state_r == FLUSH);
   assign pop_s    = (occ_r != 2'd0) && data_ready;
   assign credit_s = ((occ_r + {1'b0, inflight_r}) < 2'd2) || pop_s;
   assign read_s   = active_s && Enable && !FIFO_empty && credit_s;

   assign read_enable = read_s;
   assign data_out    = head_r;
   assign data_valid  = (occ_r != 2'd0);
   assign busy        = (state_r != IDLE) || (occ_r != 2'd0) || inflight_r;
   assign words_out   = words_out_r;

   // Next-state and burst counter logic.
   always_comb begin
      state_nxt_s     = state_r;
      burst_cnt_nxt_s = burst_cnt_r;
      case (state_r)
         IDLE: begin
            burst_cnt_nxt_s = 4'd0;
            if (Enable && !FIFO_almost_empty) begin
               state_nxt_s = BURST;
            end else if (Enable && flush && !FIFO_empty) begin
               state_nxt_s = FLUSH;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BURST: begin
            if ((read_s && (burst_cnt_r == BURST_LAST)) || FIFO_empty ||
                FIFO_almost_empty || !Enable) begin
               state_nxt_s     = IDLE;
               burst_cnt_nxt_s = 4'd0;
            end else if (read_s) begin
               state_nxt_s     = BURST;
               burst_cnt_nxt_s = burst_cnt_r + 4'd1;
            end else begin
               state_nxt_s     = BURST;
               burst_cnt_nxt_s = burst_cnt_r;
            end
         end
         FLUSH: begin
            burst_cnt_nxt_s = 4'd0;
            if ((FIFO_empty && !inflight_r) || !flush || !Enable) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = FLUSH;
            end
         end
         default: begin
            state_nxt_s     = IDLE;
            burst_cnt_nxt_s = 4'd0;
         end
      endcase
   end

   // Skid buffer: the in-flight word lands at the tail, pops shift from the head.
   always_comb begin
      head_nxt_s = head_r;
      tail_nxt_s = tail_r;
      occ_nxt_s  = occ_r;
      case ({inflight_r, pop_s})
         2'b10: begin
            occ_nxt_s = occ_r + 2'd1;
            if (occ_r == 2'd0) begin
               head_nxt_s = FIFO_data_out;
            end else begin
               tail_nxt_s = FIFO_data_out;
            end
         end
         2'b01: begin
            occ_nxt_s  = occ_r - 2'd1;
            head_nxt_s = tail_r;
         end
         2'b11: begin
            occ_nxt_s = occ_r;
            if (occ_r == 2'd1) begin
               head_nxt_s = FIFO_data_out;
            end else begin
               head_nxt_s = tail_r;
               tail_nxt_s = FIFO_data_out;
            end
         end
         default: begin
            occ_nxt_s = occ_r;
         end
      endcase
   end

   // State, buffer and counter registers.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_r     <= IDLE;
         burst_cnt_r <= 4'd0;
         occ_r       <= 2'd0;
         inflight_r  <= 1'b0;
         head_r      <= '0;
         tail_r      <= '0;
         words_out_r <= '0;
      end else begin
         state_r     <= state_nxt_s;
         burst_cnt_r <= burst_cnt_nxt_s;
         occ_r       <= occ_nxt_s;
         inflight_r  <= read_s;
         head_r      <= head_nxt_s;
         tail_r      <= tail_nxt_s;
         if (pop_s) begin
            words_out_r <= words_out_r + CNT_WIDTH'(1);
         end else begin
            words_out_r <= words_out_r;
         end
      end
   end

endmodule
